// File: rtl/bc_pkg.sv
// -----------------------------------------------------------------------------
// bc_pkg
// Purpose : Shared types and constants for the Bulls & Cows codemaker (judge).
//           This package holds the digit types, the judge FSM state encoding and
//           the secret validity check.
// Contents: DIGITS, MAX_DIGIT, digit_t, digits_t, judge_state_e, secret_valid()
// -----------------------------------------------------------------------------
package bc_pkg;

    localparam int     DIGITS    = 4;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    typedef logic [3:0] digit_t;
    // Index 0 is digit position 0.
    typedef digit_t [DIGITS-1:0] digits_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_SCORE,
        ST_PUBLISH,
        ST_ACK,
        ST_WON,
        ST_LOST
    } judge_state_e;

    // A secret is playable only if every digit is decimal and no digit repeats.
    // Distinct digits guarantee each guess digit is at most one bull or one cow.
    function automatic logic secret_valid(input digits_t s);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[i] > MAX_DIGIT) ok = 1'b0;
            for (int k = i + 1; k < DIGITS; k++) begin
                if (s[i] == s[k]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bc_digit_score.sv
// -----------------------------------------------------------------------------
// bc_digit_score
// Purpose : Combinational score of one guess digit against the whole secret.
// Ports   : g_j     in  guess digit at position j
//           j       in  position of g_j (0..3)
//           secret  in  the four secret digits
//           is_bull out g_j equals the secret digit at position j
//           is_cow  out g_j appears in the secret, but only at another position
//           is_bad  out g_j is not a decimal digit (>9); such digits never match
// -----------------------------------------------------------------------------
module bc_digit_score
    import bc_pkg::*;
(
    input  digit_t      g_j,
    input  logic [1:0]  j,
    input  digits_t     secret,
    output logic        is_bull,
    output logic        is_cow,
    output logic        is_bad
);

    logic in_other;

    // NOTE: every output of a combinational block is assigned a default at the
    // top so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        is_bad   = (g_j > MAX_DIGIT);
        in_other = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if ((2'(k) != j) && (secret[k] == g_j)) in_other = 1'b1;
        end
        is_bull = !is_bad && (g_j == secret[j]);
        is_cow  = !is_bad && !is_bull && in_other;
    end

endmodule

// File: rtl/bc_judge.sv
// -----------------------------------------------------------------------------
// bc_judge
// Purpose : Codemaker side of the Bulls & Cows frame protocol. Holds a 4-digit
//           secret, accepts one guess per write_frame/frame_written four-phase
//           handshake, scores it one digit per cycle and publishes bulls/cows.
//           Also tracks the guess count and the win/loss outcome.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           secret_load, secret_in_* 1-cycle load strobe and secret digits
//           guessed_number_*         guess digits, sampled at capture
//           write_frame              solver request (guess valid)
//           frame_written            score valid / request acknowledged
//           bulls, cows              last published score (0..4 each)
//           guess_count              guesses scored this game, saturating
//           won, lost                game outcome levels
//           secret_err               1-cycle pulse on a rejected secret_load
//           bad_digit                last scored guess contained a digit >9
// -----------------------------------------------------------------------------
module bc_judge
    import bc_pkg::*;
#(
    parameter int MAX_GUESSES = 16,
    parameter int CNT_W       = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             secret_load,
    input  logic [3:0]       secret_in_0,
    input  logic [3:0]       secret_in_1,
    input  logic [3:0]       secret_in_2,
    input  logic [3:0]       secret_in_3,
    input  logic [3:0]       guessed_number_0,
    input  logic [3:0]       guessed_number_1,
    input  logic [3:0]       guessed_number_2,
    input  logic [3:0]       guessed_number_3,
    input  logic             write_frame,
    output logic             frame_written,
    output logic [2:0]       bulls,
    output logic [2:0]       cows,
    output logic [CNT_W-1:0] guess_count,
    output logic             won,
    output logic             lost,
    output logic             secret_err,
    output logic             bad_digit
);

    judge_state_e     state_q, state_d;
    digits_t          secret_q, secret_d;
    digits_t          guess_q, guess_d;
    logic [1:0]       j_q, j_d;
    logic [2:0]       bulls_acc_q, bulls_acc_d;
    logic [2:0]       cows_acc_q, cows_acc_d;
    logic             bad_acc_q, bad_acc_d;
    logic [2:0]       bulls_q, bulls_d;
    logic [2:0]       cows_q, cows_d;
    logic             bad_q, bad_d;
    logic             fw_q, fw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    digits_t secret_in;
    digits_t guess_in;
    logic    is_bull, is_cow, is_bad;
    logic    load_allowed;

    assign secret_in = {secret_in_3, secret_in_2, secret_in_1, secret_in_0};
    assign guess_in  = {guessed_number_3, guessed_number_2,
                        guessed_number_1, guessed_number_0};

    bc_digit_score u_score (
        .g_j     (guess_q[j_q]),
        .j       (j_q),
        .secret  (secret_q),
        .is_bull (is_bull),
        .is_cow  (is_cow),
        .is_bad  (is_bad)
    );

    // A new secret may only replace the old one when no guess is in flight.
    assign load_allowed = (state_q == ST_IDLE) || (state_q == ST_WON) ||
                          (state_q == ST_LOST);

    // -------------------------------------------------------------------------
    // State register (and datapath registers)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    // NOTE: this block has no memories, so every flop is reset; frame_written
    // therefore drops as soon as rst rises, with no clock edge needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            secret_q    <= '0;
            guess_q     <= '0;
            j_q         <= '0;
            bulls_acc_q <= '0;
            cows_acc_q  <= '0;
            bad_acc_q   <= 1'b0;
            bulls_q     <= '0;
            cows_q      <= '0;
            bad_q       <= 1'b0;
            fw_q        <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            guess_q     <= guess_d;
            j_q         <= j_d;
            bulls_acc_q <= bulls_acc_d;
            cows_acc_q  <= cows_acc_d;
            bad_acc_q   <= bad_acc_d;
            bulls_q     <= bulls_d;
            cows_q      <= cows_d;
            bad_q       <= bad_d;
            fw_q        <= fw_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        guess_d     = guess_q;
        j_d         = j_q;
        bulls_acc_d = bulls_acc_q;
        cows_acc_d  = cows_acc_q;
        bad_acc_d   = bad_acc_q;
        bulls_d     = bulls_q;
        cows_d      = cows_q;
        bad_d       = bad_q;
        fw_d        = fw_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;

        if (secret_load && load_allowed) begin
            if (secret_valid(secret_in)) begin
                secret_d = secret_in;
                cnt_d    = '0;
                bulls_d  = '0;
                cows_d   = '0;
                state_d  = ST_READY;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_WON, ST_LOST: ; // only secret_load acts here
            ST_READY: begin
                if (write_frame) begin
                    guess_d     = guess_in;
                    bulls_acc_d = '0;
                    cows_acc_d  = '0;
                    bad_acc_d   = 1'b0;
                    j_d         = '0;
                    state_d     = ST_SCORE;
                end
            end
            ST_SCORE: begin
                bulls_acc_d = bulls_acc_q + 3'(is_bull);
                cows_acc_d  = cows_acc_q + 3'(is_cow);
                bad_acc_d   = bad_acc_q | is_bad;
                j_d         = j_q + 2'd1;
                if (j_q == 2'd3) state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                bulls_d = bulls_acc_q;
                cows_d  = cows_acc_q;
                bad_d   = bad_acc_q;
                fw_d    = 1'b1;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // Hold the acknowledge until the solver releases its request;
                // a win on the final guess beats the loss.
                if (!write_frame) begin
                    fw_d = 1'b0;
                    if (bulls_q == 3'd4)                     state_d = ST_WON;
                    else if (cnt_q == CNT_W'(MAX_GUESSES))   state_d = ST_LOST;
                    else                                      state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        won           = (state_q == ST_WON);
        lost          = (state_q == ST_LOST);
        frame_written = fw_q;
        bulls         = bulls_q;
        cows          = cows_q;
        guess_count   = cnt_q;
        secret_err    = err_q;
        bad_digit     = bad_q;
    end

endmodule

// File: tb/tb_bc_judge.sv
// -----------------------------------------------------------------------------
// tb_bc_judge
// Directed test of bc_judge. A second instance with MAX_GUESSES=3 shares all
// inputs and is observed only where the loss rule matters.
// -----------------------------------------------------------------------------
module tb_bc_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       secret_load = 1'b0;
    logic [3:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic [3:0] g0 = '0, g1 = '0, g2 = '0, g3 = '0;
    logic       write_frame = 1'b0;

    logic       frame_written, won, lost, secret_err, bad_digit;
    logic [2:0] bulls, cows;
    logic [7:0] guess_count;

    logic       fw3, won3, lost3, err3, bad3;
    logic [2:0] bulls3, cows3;
    logic [7:0] cnt3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bc_judge dut (
        .clk(clk), .rst(rst), .secret_load(secret_load),
        .secret_in_0(s0), .secret_in_1(s1), .secret_in_2(s2), .secret_in_3(s3),
        .guessed_number_0(g0), .guessed_number_1(g1),
        .guessed_number_2(g2), .guessed_number_3(g3),
        .write_frame(write_frame), .frame_written(frame_written),
        .bulls(bulls), .cows(cows), .guess_count(guess_count),
        .won(won), .lost(lost), .secret_err(secret_err), .bad_digit(bad_digit)
    );

    bc_judge #(.MAX_GUESSES(3)) dut3 (
        .clk(clk), .rst(rst), .secret_load(secret_load),
        .secret_in_0(s0), .secret_in_1(s1), .secret_in_2(s2), .secret_in_3(s3),
        .guessed_number_0(g0), .guessed_number_1(g1),
        .guessed_number_2(g2), .guessed_number_3(g3),
        .write_frame(write_frame), .frame_written(fw3),
        .bulls(bulls3), .cows(cows3), .guess_count(cnt3),
        .won(won3), .lost(lost3), .secret_err(err3), .bad_digit(bad3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        check("rst_fw",    32'(frame_written), 0);
        check("rst_bulls", 32'(bulls), 0);
        check("rst_cnt",   32'(guess_count), 0);
        check("rst_won",   32'(won), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a secret for one cycle and check the error pulse that follows.
    task automatic load_secret(input logic [3:0] a, b, c, d, input logic exp_err, input string tag);
        @(negedge clk);
        s0 = a; s1 = b; s2 = c; s3 = d;
        secret_load = 1'b1;
        @(negedge clk);
        secret_load = 1'b0;
        check({tag, "_err"}, 32'(secret_err), 32'(exp_err));
        if (exp_err) begin
            @(negedge clk);
            check({tag, "_err_pulse"}, 32'(secret_err), 0);
        end
    endtask

    // One full handshake. Edges are counted with the capture edge as edge 1.
    task automatic play(input logic [3:0] a, b, c, d, input int eb, ec, ebad,
                        input bit chk_lat, input string tag);
        int  n;
        bit  seen;
        @(negedge clk);
        g0 = a; g1 = b; g2 = c; g3 = d;
        write_frame = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame_written) seen = 1'b1;
        end
        check({tag, "_ack_seen"}, 32'(seen), 1);
        if (chk_lat) check({tag, "_latency"}, 32'(n), 6);
        check({tag, "_bulls"}, 32'(bulls), 32'(eb));
        check({tag, "_cows"},  32'(cows), 32'(ec));
        check({tag, "_bad"},   32'(bad_digit), 32'(ebad));
        write_frame = 1'b0;
        @(negedge clk);
        check({tag, "_fw_drop"}, 32'(frame_written), 0);
    endtask

    initial begin
        int hi;

        // Reset state
        #2;
        do_reset();
        check("rst_err", 32'(secret_err), 0);
        check("rst_lost", 32'(lost), 0);

        // Invalid secrets from IDLE, and IDLE ignores write_frame
        load_secret(1, 1, 2, 3, 1'b1, "sec_dup");
        @(negedge clk);
        write_frame = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_written) hi++;
        end
        write_frame = 1'b0;
        check("idle_stall", 32'(hi), 0);
        load_secret(1, 2, 10, 4, 1'b1, "sec_a");

        // Secret 1234: two guesses to a win
        load_secret(1, 2, 3, 4, 1'b0, "sec_1234");
        check("load_cnt", 32'(guess_count), 0);
        play(1, 2, 4, 3, 2, 2, 0, 1'b1, "g1243");
        check("g1243_cnt",  32'(guess_count), 1);
        check("g1243_hold", 32'(bulls), 2);
        check("g1243_won",  32'(won), 0);
        play(1, 2, 3, 4, 4, 0, 0, 1'b1, "g1234");
        check("g1234_cnt", 32'(guess_count), 2);
        check("g1234_won", 32'(won), 1);

        // Rejected load in WON leaves the game over
        load_secret(1, 1, 2, 3, 1'b1, "sec_won_dup");
        check("won_kept", 32'(won), 1);

        // New game 5678 with a bad digit, then a solver run to a win
        load_secret(5, 6, 7, 8, 1'b0, "sec_5678");
        check("new_won",   32'(won), 0);
        check("new_bulls", 32'(bulls), 0);
        play(0, 0, 0, 15, 0, 0, 1, 1'b0, "gbad");
        play(8, 7, 6, 5, 0, 4, 0, 1'b0, "g8765");
        play(5, 6, 8, 7, 2, 2, 0, 1'b0, "g5687");
        play(5, 6, 7, 8, 4, 0, 0, 1'b0, "g5678");
        check("g5678_won", 32'(won), 1);
        check("g5678_cnt", 32'(guess_count), 4);

        // Request dropped before the acknowledge: one-cycle frame_written
        load_secret(1, 2, 3, 4, 1'b0, "sec_viol");
        @(negedge clk);
        g0 = 1; g1 = 2; g2 = 4; g3 = 3;
        write_frame = 1'b1;
        @(negedge clk);
        write_frame = 1'b0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_written) hi++;
        end
        check("viol_fw_cycles", 32'(hi), 1);
        check("viol_bulls", 32'(bulls), 2);
        check("viol_cows",  32'(cows), 2);

        // Reset while scoring
        @(negedge clk);
        write_frame = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_score_bulls", 32'(bulls), 0);
        check("rst_score_cnt",   32'(guess_count), 0);
        @(negedge clk);
        rst = 1'b0;
        write_frame = 1'b0;

        // Reset while acknowledging
        load_secret(1, 2, 3, 4, 1'b0, "sec_ack");
        @(negedge clk);
        g0 = 1; g1 = 2; g2 = 4; g3 = 3;
        write_frame = 1'b1;
        hi = 0;
        while (!frame_written && hi < 20) begin
            @(negedge clk);
            hi++;
        end
        check("ack_reached", 32'(frame_written), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_ack_fw",    32'(frame_written), 0);
        check("rst_ack_bulls", 32'(bulls), 0);
        @(negedge clk);
        rst = 1'b0;
        write_frame = 1'b0;
        load_secret(9, 0, 1, 2, 1'b0, "sec_resume");
        play(9, 0, 1, 2, 4, 0, 0, 1'b1, "g9012");
        check("resume_won", 32'(won), 1);

        // Loss after MAX_GUESSES=3 on the small instance
        do_reset();
        load_secret(1, 2, 3, 4, 1'b0, "sec_lose");
        play(5, 6, 7, 8, 0, 0, 0, 1'b0, "lose1");
        check("lose1_lost3", 32'(lost3), 0);
        play(5, 6, 7, 8, 0, 0, 0, 1'b0, "lose2");
        check("lose2_lost3", 32'(lost3), 0);
        play(5, 6, 7, 8, 0, 0, 0, 1'b0, "lose3");
        check("lose3_lost3", 32'(lost3), 1);
        check("lose3_cnt3",  32'(cnt3), 3);
        check("lose3_lost16", 32'(lost), 0);
        @(negedge clk);
        write_frame = 1'b1;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fw3) hi++;
        end
        write_frame = 1'b0;
        check("lose4_no_ack", 32'(hi), 0);
        check("lose4_lost3",  32'(lost3), 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
